// File: rtl/adc_motor_pkg.sv
// adc_motor_pkg
// Shared types and helpers for the ADC-fed PWM motor controller.
//   state_e : controller sequencing state
//   dir_e   : drive direction; DIR_NONE doubles as the STOP demand
//   sat_shl : left shift with saturation to an out_w-bit all-ones value
package adc_motor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DEAD  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_FWD  = 2'd1,
    DIR_REV  = 2'd2
  } dir_e;

  // Shift mag left by sh and clamp to (2^out_w)-1.
  function automatic logic [31:0] sat_shl(input logic [31:0] mag, input int sh, input int out_w);
    logic [63:0] wide_s;
    logic [63:0] max_s;
    wide_s = {32'd0, mag} << sh;
    max_s  = (64'd1 << out_w) - 64'd1;
    if (wide_s > max_s) begin
      return max_s[31:0];
    end else begin
      return wide_s[31:0];
    end
  endfunction

endpackage

// File: rtl/adc_pwm_motor_ctrl_pwm_gen.sv
// pwm_gen
// Free-running PWM_W-bit counter with a registered compare output.
//   clk, reset : clock, asynchronous active-low reset
//   duty       : high time in counts per 2^PWM_W-cycle period
//   pwm        : registered (cnt < duty); duty 0 never high, all-ones low 1 cycle
module pwm_gen #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PWM_W-1:0] duty,
  output logic             pwm
);

  logic [PWM_W-1:0] cnt_r;
  logic             pwm_r;

  // Period counter and registered duty compare.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {PWM_W{1'b0}};
      pwm_r <= 1'b0;
    end else begin
      cnt_r <= cnt_r + PWM_W'(1);
      pwm_r <= (cnt_r < duty);
    end
  end

  assign pwm = pwm_r;

endmodule

// File: rtl/adc_pwm_motor_ctrl.sv
// adc_pwm_motor_ctrl
// Closed-loop DC motor driver: compares each ADC sample to a setpoint with
// hysteresis, derives a direction and proportional target duty, and
// soft-ramps PWM duty toward it. Reversal drains to zero and inserts dead time.
//   clk, reset             : clock, async-assert / sync-release active-low reset
//   sample, sample_vld     : ADC result and its one-cycle strobe
//   setpoint               : regulation threshold, sampled with sample_vld
//   enable                 : run request, low = soft stop
//   motor_en               : registered copy of enable
//   motor                  : [1] forward PWM, [0] reverse PWM
//   duty                   : currently applied duty
//   busy                   : controller not idle
module adc_pwm_motor_ctrl
  import adc_motor_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int PWM_W    = 8,
  parameter int HYST     = 4,
  parameter int GAIN_SH  = 2,
  parameter int RAMP_DIV = 256,
  parameter int DEAD_CYC = 64,
  parameter int BIDIR    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_vld,
  input  logic [DATA_W-1:0] setpoint,
  input  logic              enable,
  output logic              motor_en,
  output logic [1:0]        motor,
  output logic [PWM_W-1:0]  duty,
  output logic              busy
);

  localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DC_W  = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);
  localparam logic [DC_W-1:0]  DEAD_LAST = DC_W'(DEAD_CYC - 1);
  localparam logic signed [DATA_W:0] HYST_P = (DATA_W+1)'(HYST);
  localparam logic signed [DATA_W:0] HYST_N = -HYST_P;

  logic [1:0]         rst_sync_r;
  logic               reset_s;
  logic signed [DATA_W:0] err_s;
  logic [DATA_W:0]    abs_s;
  logic [PWM_W-1:0]   target_calc_s;
  dir_e               demand_r, demand_nxt_s;
  logic [PWM_W-1:0]   target_r, target_nxt_s, tgt_eff_s;
  logic [PRE_W-1:0]   presc_r;
  logic               tick_s;
  state_e             state_r, state_nxt_s;
  dir_e               dir_r, dir_nxt_s;
  logic [PWM_W-1:0]   duty_r, duty_nxt_s;
  logic [DC_W-1:0]    dead_cnt_r;
  logic               motor_en_r;
  logic               pwm_s;
  logic               fwd_on_s, rev_on_s;

  // Reset synchronizer: assertion is immediate, release waits two clocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end
  assign reset_s = rst_sync_r[1];

  // Error is one bit wider than the inputs so it never wraps.
  assign err_s         = $signed({1'b0, sample}) - $signed({1'b0, setpoint});
  assign abs_s         = err_s[DATA_W] ? -err_s : err_s;
  assign target_calc_s = PWM_W'(sat_shl(32'(abs_s), GAIN_SH, PWM_W));

  // Demand/target update with hysteresis; inside the band both hold.
  always_comb begin
    demand_nxt_s = demand_r;
    target_nxt_s = target_r;
    if (sample_vld) begin
      if (err_s > HYST_P) begin
        demand_nxt_s = DIR_FWD;
        target_nxt_s = target_calc_s;
      end else if (err_s < HYST_N) begin
        if (BIDIR != 0) begin
          demand_nxt_s = DIR_REV;
          target_nxt_s = target_calc_s;
        end else begin
          demand_nxt_s = DIR_NONE;
          target_nxt_s = {PWM_W{1'b0}};
        end
      end else begin
        demand_nxt_s = demand_r;
      end
    end else begin
      demand_nxt_s = demand_r;
    end
  end

  // Soft stop forces the ramp goal to zero without losing the stored target.
  assign tgt_eff_s = enable ? target_r : {PWM_W{1'b0}};
  assign tick_s    = (presc_r == PRE_LAST);

  // Sequencing: ramp in RUN, drain on reversal/stop, then fixed dead time.
  always_comb begin
    state_nxt_s = state_r;
    dir_nxt_s   = dir_r;
    duty_nxt_s  = duty_r;
    case (state_r)
      ST_IDLE: begin
        duty_nxt_s = {PWM_W{1'b0}};
        if (enable && (demand_r != DIR_NONE)) begin
          state_nxt_s = ST_RUN;
          dir_nxt_s   = demand_r;
        end else begin
          dir_nxt_s = DIR_NONE;
        end
      end
      ST_RUN: begin
        if (!enable || (demand_r != dir_r)) begin
          state_nxt_s = ST_DRAIN;
        end else if (tick_s && (duty_r < tgt_eff_s)) begin
          duty_nxt_s = duty_r + PWM_W'(1);
        end else if (tick_s && (duty_r > tgt_eff_s)) begin
          duty_nxt_s = duty_r - PWM_W'(1);
        end else begin
          duty_nxt_s = duty_r;
        end
      end
      ST_DRAIN: begin
        if (duty_r == {PWM_W{1'b0}}) begin
          state_nxt_s = ST_DEAD;
        end else if (tick_s) begin
          duty_nxt_s = duty_r - PWM_W'(1);
        end else begin
          duty_nxt_s = duty_r;
        end
      end
      ST_DEAD: begin
        if (dead_cnt_r == DEAD_LAST) begin
          if (enable && (demand_r != DIR_NONE)) begin
            state_nxt_s = ST_RUN;
            dir_nxt_s   = demand_r;
          end else begin
            state_nxt_s = ST_IDLE;
            dir_nxt_s   = DIR_NONE;
          end
        end else begin
          state_nxt_s = ST_DEAD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        dir_nxt_s   = DIR_NONE;
        duty_nxt_s  = {PWM_W{1'b0}};
      end
    endcase
  end

  // State, demand, prescaler, dead-time counter and enable registers.
  always_ff @(posedge clk or negedge reset_s) begin
    if (!reset_s) begin
      state_r    <= ST_IDLE;
      dir_r      <= DIR_NONE;
      duty_r     <= {PWM_W{1'b0}};
      demand_r   <= DIR_NONE;
      target_r   <= {PWM_W{1'b0}};
      presc_r    <= {PRE_W{1'b0}};
      dead_cnt_r <= {DC_W{1'b0}};
      motor_en_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      dir_r      <= dir_nxt_s;
      duty_r     <= duty_nxt_s;
      demand_r   <= demand_nxt_s;
      target_r   <= target_nxt_s;
      presc_r    <= tick_s ? {PRE_W{1'b0}} : presc_r + PRE_W'(1);
      dead_cnt_r <= (state_r == ST_DEAD) ? dead_cnt_r + DC_W'(1) : {DC_W{1'b0}};
      motor_en_r <= enable;
    end
  end

  pwm_gen #(.PWM_W(PWM_W)) u_pwm (
    .clk   (clk),
    .reset (reset_s),
    .duty  (duty_r),
    .pwm   (pwm_s)
  );

  // Drive gating is built only from registers, so one direction is ever live.
  assign fwd_on_s = ((state_r == ST_RUN) || (state_r == ST_DRAIN)) && (dir_r == DIR_FWD);
  assign rev_on_s = ((state_r == ST_RUN) || (state_r == ST_DRAIN)) && (dir_r == DIR_REV);
  assign motor    = {pwm_s & fwd_on_s, pwm_s & rev_on_s};
  assign motor_en = motor_en_r;
  assign duty     = duty_r;
  assign busy     = (state_r != ST_IDLE);

endmodule

// File: tb/tb_adc_pwm_motor_ctrl.sv
// tb_adc_pwm_motor_ctrl
// Directed bench: a bidirectional instance and a BIDIR=0 instance share stimulus.
module tb_adc_pwm_motor_ctrl;
  import adc_motor_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] sample = 8'd0;
  logic       sample_vld = 1'b0;
  logic [7:0] setpoint = 8'd0;
  logic       enable = 1'b0;
  logic       motor_en, busy, motor_en_u, busy_u;
  logic [1:0] motor, motor_u;
  logic [7:0] duty, duty_u;
  logic       rev_seen_u = 1'b0;
  logic       both_seen = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc, hi1, hi0, dead_n, dead_bad;

  adc_pwm_motor_ctrl #(.DATA_W(8), .PWM_W(8), .HYST(4), .GAIN_SH(2), .RAMP_DIV(4),
                       .DEAD_CYC(8), .BIDIR(1)) dut (
    .clk(clk), .reset(reset), .sample(sample), .sample_vld(sample_vld),
    .setpoint(setpoint), .enable(enable), .motor_en(motor_en), .motor(motor),
    .duty(duty), .busy(busy));

  adc_pwm_motor_ctrl #(.DATA_W(8), .PWM_W(8), .HYST(4), .GAIN_SH(2), .RAMP_DIV(4),
                       .DEAD_CYC(8), .BIDIR(0)) dut_u (
    .clk(clk), .reset(reset), .sample(sample), .sample_vld(sample_vld),
    .setpoint(setpoint), .enable(enable), .motor_en(motor_en_u), .motor(motor_u),
    .duty(duty_u), .busy(busy_u));

  always #5 clk = ~clk;

  // Sticky monitors for drive conditions that must never occur.
  always @(posedge clk) begin
    if (motor_u[0]) rev_seen_u <= 1'b1;
    if (motor[1] && motor[0]) both_seen <= 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] smp, input logic [7:0] sp);
    sample = smp;
    setpoint = sp;
    sample_vld = 1'b1;
    step();
    sample_vld = 1'b0;
  endtask

  task automatic wait_duty(input logic [7:0] val, input int limit, output int n);
    n = 0;
    while (duty !== val && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic count_motor(output int h1, output int h0);
    h1 = 0;
    h0 = 0;
    for (int i = 0; i < 256; i++) begin
      if (motor[1]) h1++;
      if (motor[0]) h0++;
      step();
    end
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_motor", motor, 2'b00);
    chk("rst_motor_en", motor_en, 1'b0);
    chk("rst_duty", duty, 8'd0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b1;
    repeat (4) step();
    chk("post_rst_busy", busy, 1'b0);

    // Forward run: error 50 -> target 200
    enable = 1'b1;
    chk("motor_en_lag", motor_en, 1'b0);
    pulse(8'd150, 8'd100);
    chk("motor_en_follow", motor_en, 1'b1);
    chk("busy_n1", busy, 1'b0);
    step();
    chk("busy_n2", busy, 1'b1);
    wait_duty(8'd200, 1200, cyc);
    chk("fwd_duty_200", duty, 8'd200);
    chk("fwd_ramp_time", (cyc >= 797 && cyc <= 800), 1'b1);
    chk("u_fwd_duty_200", duty_u, 8'd200);
    repeat (16) step();
    chk("fwd_no_overshoot", duty, 8'd200);
    count_motor(hi1, hi0);
    chk("fwd_hi_count", hi1, 200);
    chk("fwd_rev_bit_low", hi0, 0);

    // Sample inside the hysteresis band: nothing changes
    pulse(8'd97, 8'd100);
    repeat (20) step();
    chk("band_duty", duty, 8'd200);
    chk("band_state", dut.state_r, ST_RUN);
    count_motor(hi1, hi0);
    chk("band_hi_count", hi1, 200);
    chk("band_rev_low", hi0, 0);

    // Reverse request: drain 200 ticks, 8 dead cycles, then ramp reverse
    pulse(8'd50, 8'd100);
    cyc = 0;
    while (dut.state_r !== ST_DEAD && cyc < 1200) begin
      step();
      cyc++;
    end
    chk("drain_to_dead_time", (cyc >= 799 && cyc <= 802), 1'b1);
    chk("drain_duty_zero", duty, 8'd0);
    dead_n = 0;
    dead_bad = 0;
    while (dut.state_r === ST_DEAD && dead_n < 100) begin
      if (motor !== 2'b00) dead_bad++;
      dead_n++;
      step();
    end
    chk("dead_len", dead_n, 8);
    chk("dead_motor_zero", dead_bad, 0);
    chk("rev_state_run", dut.state_r, ST_RUN);
    chk("u_stop_idle", busy_u, 1'b0);
    chk("u_stop_duty", duty_u, 8'd0);
    wait_duty(8'd200, 1200, cyc);
    chk("rev_duty_200", duty, 8'd200);
    repeat (16) step();
    count_motor(hi1, hi0);
    chk("rev_fwd_low", hi1, 0);
    chk("rev_hi_count", hi0, 200);

    // Saturation: error 255 << 2 clamps to 255
    pulse(8'd255, 8'd0);
    wait_duty(8'd255, 3000, cyc);
    chk("sat_duty", duty, 8'd255);
    repeat (16) step();
    count_motor(hi1, hi0);
    chk("sat_hi_count", hi1, 255);
    chk("sat_rev_low", hi0, 0);
    chk("u_sat_duty", duty_u, 8'd255);
    chk("u_never_rev", rev_seen_u, 1'b0);

    // Ramp down to 120, then soft stop
    pulse(8'd30, 8'd0);
    wait_duty(8'd120, 1000, cyc);
    chk("down_duty_120", duty, 8'd120);
    enable = 1'b0;
    chk("stop_motor_en_lag", motor_en, 1'b1);
    step();
    chk("stop_motor_en", motor_en, 1'b0);
    chk("stop_busy", busy, 1'b1);
    cyc = 0;
    while (busy !== 1'b0 && cyc < 1000) begin
      step();
      cyc++;
    end
    chk("stop_to_idle_time", (cyc >= 486 && cyc <= 489), 1'b1);
    chk("stop_duty", duty, 8'd0);
    chk("stop_motor", motor, 2'b00);

    // Reset asserted mid-run
    enable = 1'b1;
    pulse(8'd150, 8'd100);
    repeat (40) step();
    chk("mid_pre_busy", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_motor", motor, 2'b00);
    chk("mid_rst_duty", duty, 8'd0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_motor_en", motor_en, 1'b0);
    repeat (2) step();
    reset = 1'b1;
    repeat (6) step();
    chk("mid_rel_state", dut.state_r, ST_IDLE);
    chk("mid_rel_duty", duty, 8'd0);
    chk("never_both_bits", both_seen, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_pwm_motor_ctrl.md
# adc_pwm_motor_ctrl

Parametrised closed-loop DC motor driver fed by the ADC sequencer's conversion results. Compares each new sample against a setpoint with a hysteresis band, derives direction and a proportional target duty, and soft-ramps a PWM duty cycle toward that target. Direction reversal always drains to zero duty and inserts a dead time. Sits between the ADC sequencer and the H-bridge pins, replacing on/off threshold motor control.

## Interface
- DATA_W, 8: ADC sample / setpoint width
- PWM_W, 8: duty and PWM counter width (period = 2^PWM_W clk)
- HYST, 4: hysteresis half-band in LSBs
- GAIN_SH, 2: target duty = |error| << GAIN_SH, saturated
- RAMP_DIV, 256: clk cycles per ±1 duty step (≥1)
- DEAD_CYC, 64: zero-drive clk cycles between directions (≥1)
- BIDIR, 1: 1 = reverse allowed; 0 = below band means stop

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- sample  in  DATA_W  ADC conversion result
- sample_vld  in  1  one-cycle strobe, sample valid
- setpoint  in  DATA_W  regulation threshold, sampled with sample_vld
- enable  in  1  run request; low = soft stop
- motor_en  out  1  H-bridge enable, registered copy of enable
- motor  out  2  bridge drive: [1] = forward PWM, [0] = reverse PWM
- duty  out  PWM_W  current applied duty
- busy  out  1  state ≠ IDLE

## Operation
- error = sample − setpoint, signed DATA_W+1. Evaluated only on sample_vld.
- Demand update:
  - error > HYST → FWD.
  - error < −HYST → REV if BIDIR, else STOP.
  - |error| ≤ HYST → demand and target hold previous values.
- target = min(|error| << GAIN_SH, 2^PWM_W−1) whenever demand is updated. target = 0 when demand is STOP or enable = 0.
- Ramp tick: free-running prescaler 0..RAMP_DIV−1. One tick on wrap.
- States:
  - IDLE: duty 0, dir NONE. Leaves for RUN when enable && demand ∈ {FWD, REV}, latching dir = demand.
  - RUN: on each tick, duty steps ±1 toward target. Duty never overshoots target. Goes to DRAIN when demand ≠ dir or enable = 0.
  - DRAIN: on each tick, duty −1. When duty = 0, goes to DEAD.
  - DEAD: motor = 00 for DEAD_CYC cycles. Then goes to RUN with dir = demand if enable && demand ∈ {FWD, REV}, else to IDLE.
- PWM: PWM_W-bit counter free-runs; pwm = (cnt < duty). duty = 0 → never high; duty = 2^PWM_W−1 → low 1 cycle per period.
- Drive outputs: motor = dir FWD ? {pwm,0} : dir REV ? {0,pwm} : 00. Both bits are never high together. motor = 00 in IDLE and DEAD.
- An opposite-side sample during DRAIN or DEAD only updates demand. It never shortens DEAD.

## Timing
- Reset (async assert, sync release) clears everything:
  - motor = 00, motor_en = 0, duty = 0, busy = 0
  - state IDLE, dir NONE, demand STOP, target 0
  - PWM counter 0, prescaler 0
- sample_vld at cycle n → demand/target valid at n+1. State transition is evaluated at n+1 and visible at n+2.
- Duty changes only on a ramp tick. It reaches target after |target − duty| ticks.
- motor reflects a duty change one cycle after duty updates; pwm compare is registered.
- motor_en follows enable with one register delay.
- sample_vld and tick in the same cycle: the duty step uses the old target.
- Reset mid-operation drops drive to 00 immediately. No ramp-down.

## Structure
- Package adc_motor_pkg: state enum (IDLE, RUN, DRAIN, DEAD), dir enum (NONE, FWD, REV), saturate-shift function.
- Sub-module pwm_gen (counter + compare, PWM_W parameter). It is reusable for other actuators. Everything else is inline.

## Test plan
Bench parameters: DATA_W=8, PWM_W=8, HYST=4, GAIN_SH=2, RAMP_DIV=4, DEAD_CYC=8, BIDIR=1.
- Reset asserted mid-run → motor=00, duty=0, busy=0, motor_en=0 in the same cycle; state IDLE after release.
- enable=1, setpoint=100, sample=150 strobe → target 200. Duty reaches 200 after 200 ticks (800 clk). motor[1] is high 200 of every 256 cycles, motor[0]=0.
- While running FWD at duty 200, sample=97 (inside band) → duty stays 200, dir FWD, no state change.
- sample=50 → DRAIN 200 ticks to 0, then motor=00 for exactly 8 cycles. Then REV, ramping to 200 on motor[0].
- setpoint=0, sample=255 → target saturates at 255, duty 255. pwm is low exactly 1 cycle per 256. Repeat with BIDIR=0 and sample below band → drain to IDLE, no reverse.
- enable dropped at duty 120 → ramps to 0 in 120 ticks, DEAD, IDLE. motor_en=0 one cycle after enable falls.
